// File: rtl/alu_operand_sequencer_pkg.sv
// Shared control encodings for the multicycle CPU: FSM states, ALU ops, datapath mux selects
// and instruction field constants. The ALU-B select encoding here is the one the datapath uses.
package alu_operand_sequencer_pkg;

    typedef enum logic [4:0] {
        StFetch     = 5'd0,
        StFetchWait = 5'd1,
        StIrLoad    = 5'd2,
        StDecode    = 5'd3,
        StRExec     = 5'd4,
        StRWb       = 5'd5,
        StAddiExec  = 5'd6,
        StOriExec   = 5'd7,
        StImmWb     = 5'd8,
        StMemAddr   = 5'd9,
        StLwRead    = 5'd10,
        StLwMdr     = 5'd11,
        StLwWb      = 5'd12,
        StSwWrite   = 5'd13,
        StBeq       = 5'd14,
        StJump      = 5'd15,
        StExc       = 5'd16
    } state_e;

    typedef enum logic [2:0] {
        AluAdd = 3'd0,
        AluSub = 3'd1,
        AluAnd = 3'd2,
        AluOr  = 3'd3,
        AluSlt = 3'd4,
        AluSll = 3'd5
    } alu_op_e;

    typedef enum logic [1:0] {
        SrcAPc    = 2'd0,
        SrcARegA  = 2'd1,
        SrcAShamt = 2'd2
    } src_a_e;

    typedef enum logic [2:0] {
        SrcBRegB   = 3'd0,
        SrcBFour   = 3'd1,
        SrcBImm    = 3'd2,
        SrcBImmSh2 = 3'd3,
        SrcBZimm   = 3'd4
    } src_b_e;

    typedef enum logic [1:0] {
        PcAlu    = 2'd0,
        PcAluOut = 2'd1,
        PcJump   = 2'd2,
        PcExc    = 2'd3
    } pc_src_e;

    localparam logic [5:0] OpRType = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnSll = 6'h00;
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2A;

    typedef struct packed {
        src_a_e  alu_src_a;
        src_b_e  alu_src_b;
        alu_op_e alu_op;
        pc_src_e pc_source;
        logic    pc_write;
        logic    pc_write_cond;
        logic    ir_write;
        logic    mem_write;
        logic    a_b_write;
        logic    alu_out_write;
        logic    reg_write;
        logic    reg_dst;
        logic    mem_to_reg;
        logic    mdr_write;
        logic    epc_write;
    } ctrl_t;

    localparam ctrl_t CtrlIdle = '{
        alu_src_a: SrcAPc, alu_src_b: SrcBRegB, alu_op: AluAdd, pc_source: PcAlu,
        pc_write: 1'b0, pc_write_cond: 1'b0, ir_write: 1'b0, mem_write: 1'b0,
        a_b_write: 1'b0, alu_out_write: 1'b0, reg_write: 1'b0, reg_dst: 1'b0,
        mem_to_reg: 1'b0, mdr_write: 1'b0, epc_write: 1'b0
    };

    // Reset keeps the FETCH mux selects but no enables.
    localparam ctrl_t CtrlReset = '{
        alu_src_a: SrcAPc, alu_src_b: SrcBFour, alu_op: AluAdd, pc_source: PcAlu,
        pc_write: 1'b0, pc_write_cond: 1'b0, ir_write: 1'b0, mem_write: 1'b0,
        a_b_write: 1'b0, alu_out_write: 1'b0, reg_write: 1'b0, reg_dst: 1'b0,
        mem_to_reg: 1'b0, mdr_write: 1'b0, epc_write: 1'b0
    };

    function automatic logic funct_known(input logic [5:0] funct);
        return funct inside {FnSll, FnAdd, FnSub, FnAnd, FnOr, FnSlt};
    endfunction

    function automatic logic funct_traps_ovf(input logic [5:0] funct);
        return funct inside {FnAdd, FnSub};
    endfunction

endpackage

// File: rtl/alu_operand_sequencer_alu_op_decoder.sv
// Maps (state, funct) to the ALU operation and the ALU source-A select.
module alu_operand_sequencer_alu_op_decoder
    import alu_operand_sequencer_pkg::*;
(
    input  logic [4:0] state_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_op_o,
    output logic [1:0] alu_src_a_o
);

    state_e st;
    assign st = state_e'(state_i);

    always_comb begin
        alu_op_o    = AluAdd;
        alu_src_a_o = SrcAPc;
        case (st)
            StRExec: begin
                alu_src_a_o = SrcARegA;
                case (funct_i)
                    FnSub:   alu_op_o = AluSub;
                    FnAnd:   alu_op_o = AluAnd;
                    FnOr:    alu_op_o = AluOr;
                    FnSlt:   alu_op_o = AluSlt;
                    FnSll: begin
                        alu_op_o    = AluSll;
                        alu_src_a_o = SrcAShamt;
                    end
                    default: alu_op_o = AluAdd;
                endcase
            end
            StAddiExec, StMemAddr: alu_src_a_o = SrcARegA;
            StOriExec: begin
                alu_src_a_o = SrcARegA;
                alu_op_o    = AluOr;
            end
            StBeq: begin
                alu_src_a_o = SrcARegA;
                alu_op_o    = AluSub;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Multicycle CPU control FSM: sequences instruction phases and drives registered datapath
// selects, register write enables, memory strobes and PC control.
module alu_operand_sequencer
    import alu_operand_sequencer_pkg::*;
#(
    parameter int unsigned MemWait = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    input  logic       alu_zero_i,
    input  logic       overflow_i,
    output logic [1:0] alu_src_a_o,
    output logic [2:0] alu_src_b_o,
    output logic [2:0] alu_op_o,
    output logic [1:0] pc_source_o,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic       ir_write_o,
    output logic       mem_write_o,
    output logic       a_b_write_o,
    output logic       alu_out_write_o,
    output logic       reg_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       mdr_write_o,
    output logic       epc_write_o,
    output logic [4:0] state_dbg_o
);

    localparam logic [1:0] WaitInit = 2'(MemWait);

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       ovf_q, ovf_d;
    logic       run_q;
    ctrl_t      ctrl_q, ctrl_d;
    logic [2:0] dec_alu_op;
    logic [1:0] dec_src_a;

    // The branch decision is taken in the datapath through pc_write_cond.
    logic unused_alu_zero;
    assign unused_alu_zero = alu_zero_i;

    alu_operand_sequencer_alu_op_decoder u_alu_op_decoder (
        .state_i     (state_d),
        .funct_i     (funct_i),
        .alu_op_o    (dec_alu_op),
        .alu_src_a_o (dec_src_a)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        // First edge after reset re-enters FETCH so its PC write is actually issued.
        if (!run_q) begin
            state_d = StFetch;
        end else begin
            case (state_q)
                StFetch: begin
                    cnt_d   = WaitInit;
                    state_d = (MemWait == 0) ? StIrLoad : StFetchWait;
                end
                StFetchWait: begin
                    cnt_d = cnt_q - 2'd1;
                    if (cnt_q <= 2'd1) state_d = StIrLoad;
                end
                StIrLoad: state_d = StDecode;
                StDecode: begin
                    case (opcode_i)
                        OpRType:    state_d = StRExec;
                        OpAddi:     state_d = StAddiExec;
                        OpOri:      state_d = StOriExec;
                        OpLw, OpSw: state_d = StMemAddr;
                        OpBeq:      state_d = StBeq;
                        OpJ:        state_d = StJump;
                        default:    state_d = StExc;
                    endcase
                end
                StRExec: begin
                    ovf_d   = overflow_i && funct_traps_ovf(funct_i);
                    state_d = funct_known(funct_i) ? StRWb : StExc;
                end
                StAddiExec: begin
                    ovf_d   = overflow_i;
                    state_d = StImmWb;
                end
                StOriExec: begin
                    ovf_d   = 1'b0;
                    state_d = StImmWb;
                end
                StRWb, StImmWb: state_d = ovf_q ? StExc : StFetch;
                StMemAddr: begin
                    if (opcode_i == OpLw) begin
                        cnt_d   = WaitInit;
                        state_d = StLwRead;
                    end else begin
                        state_d = StSwWrite;
                    end
                end
                StLwRead: begin
                    cnt_d = cnt_q - 2'd1;
                    if (cnt_q <= 2'd1) state_d = StLwMdr;
                end
                StLwMdr: state_d = StLwWb;
                default: state_d = StFetch;
            endcase
        end
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        ctrl_d           = CtrlIdle;
        ctrl_d.alu_op    = alu_op_e'(dec_alu_op);
        ctrl_d.alu_src_a = src_a_e'(dec_src_a);
        case (state_d)
            StFetch: begin
                ctrl_d.alu_src_b = SrcBFour;
                ctrl_d.pc_source = PcAlu;
                ctrl_d.pc_write  = 1'b1;
            end
            StIrLoad: ctrl_d.ir_write = 1'b1;
            StDecode: begin
                ctrl_d.a_b_write     = 1'b1;
                ctrl_d.alu_src_b     = SrcBImmSh2;
                ctrl_d.alu_out_write = 1'b1;
            end
            StRExec: begin
                ctrl_d.alu_src_b     = SrcBRegB;
                ctrl_d.alu_out_write = 1'b1;
            end
            StRWb: begin
                ctrl_d.reg_write = !ovf_d;
                ctrl_d.reg_dst   = 1'b1;
            end
            StAddiExec, StMemAddr: begin
                ctrl_d.alu_src_b     = SrcBImm;
                ctrl_d.alu_out_write = 1'b1;
            end
            StOriExec: begin
                ctrl_d.alu_src_b     = SrcBZimm;
                ctrl_d.alu_out_write = 1'b1;
            end
            StImmWb: ctrl_d.reg_write = !ovf_d;
            StLwMdr: ctrl_d.mdr_write = 1'b1;
            StLwWb: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
            end
            StSwWrite: ctrl_d.mem_write = 1'b1;
            StBeq: begin
                ctrl_d.alu_src_b     = SrcBRegB;
                ctrl_d.pc_source     = PcAluOut;
                ctrl_d.pc_write_cond = 1'b1;
            end
            StJump: begin
                ctrl_d.pc_source = PcJump;
                ctrl_d.pc_write  = 1'b1;
            end
            StExc: begin
                ctrl_d.epc_write = 1'b1;
                ctrl_d.pc_source = PcExc;
                ctrl_d.pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StFetch;
            cnt_q   <= 2'd0;
            ovf_q   <= 1'b0;
            run_q   <= 1'b0;
            ctrl_q  <= CtrlReset;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            run_q   <= 1'b1;
            ctrl_q  <= ctrl_d;
        end
    end

    assign alu_src_a_o     = ctrl_q.alu_src_a;
    assign alu_src_b_o     = ctrl_q.alu_src_b;
    assign alu_op_o        = ctrl_q.alu_op;
    assign pc_source_o     = ctrl_q.pc_source;
    assign pc_write_o      = ctrl_q.pc_write;
    assign pc_write_cond_o = ctrl_q.pc_write_cond;
    assign ir_write_o      = ctrl_q.ir_write;
    assign mem_write_o     = ctrl_q.mem_write;
    assign a_b_write_o     = ctrl_q.a_b_write;
    assign alu_out_write_o = ctrl_q.alu_out_write;
    assign reg_write_o     = ctrl_q.reg_write;
    assign reg_dst_o       = ctrl_q.reg_dst;
    assign mem_to_reg_o    = ctrl_q.mem_to_reg;
    assign mdr_write_o     = ctrl_q.mdr_write;
    assign epc_write_o     = ctrl_q.epc_write;
    assign state_dbg_o     = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer: one instance with MemWait=1, one with MemWait=2.
module tb_alu_operand_sequencer;

    localparam int SFetch = 0, SFetchWait = 1, SIrLoad = 2, SDecode = 3, SRExec = 4, SRWb = 5;
    localparam int SAddi = 6, SOri = 7, SImmWb = 8, SMemAddr = 9, SLwRead = 10, SLwMdr = 11;
    localparam int SLwWb = 12, SSw = 13, SBeq = 14, SJump = 15, SExc = 16;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [5:0] opcode_i = 6'h00;
    logic [5:0] funct_i = 6'h20;
    logic       alu_zero_i = 1'b0;
    logic       overflow_i = 1'b0;

    logic [1:0] alu_src_a, pc_source;
    logic [2:0] alu_src_b, alu_op;
    logic       pc_write, pc_write_cond, ir_write, mem_write, a_b_write, alu_out_write;
    logic       reg_write, reg_dst, mem_to_reg, mdr_write, epc_write;
    logic [4:0] state_dbg;

    logic [1:0] alu_src_a2, pc_source2;
    logic [2:0] alu_src_b2, alu_op2;
    logic       pc_write2, pc_write_cond2, ir_write2, mem_write2, a_b_write2, alu_out_write2;
    logic       reg_write2, reg_dst2, mem_to_reg2, mdr_write2, epc_write2;
    logic [4:0] state_dbg2;

    int errors = 0;
    int checks = 0;

    int lw1_seq [11] = '{0, 1, 2, 3, 9, 10, 11, 12, 0, 1, 2};
    int lw2_seq [11] = '{0, 1, 1, 2, 3, 9, 10, 10, 11, 12, 0};

    always #5 clk_i = ~clk_i;

    alu_operand_sequencer #(.MemWait(1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .opcode_i(opcode_i), .funct_i(funct_i),
        .alu_zero_i(alu_zero_i), .overflow_i(overflow_i),
        .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op),
        .pc_source_o(pc_source), .pc_write_o(pc_write), .pc_write_cond_o(pc_write_cond),
        .ir_write_o(ir_write), .mem_write_o(mem_write), .a_b_write_o(a_b_write),
        .alu_out_write_o(alu_out_write), .reg_write_o(reg_write), .reg_dst_o(reg_dst),
        .mem_to_reg_o(mem_to_reg), .mdr_write_o(mdr_write), .epc_write_o(epc_write),
        .state_dbg_o(state_dbg)
    );

    alu_operand_sequencer #(.MemWait(2)) dut2 (
        .clk_i(clk_i), .rst_ni(rst_ni), .opcode_i(opcode_i), .funct_i(funct_i),
        .alu_zero_i(alu_zero_i), .overflow_i(overflow_i),
        .alu_src_a_o(alu_src_a2), .alu_src_b_o(alu_src_b2), .alu_op_o(alu_op2),
        .pc_source_o(pc_source2), .pc_write_o(pc_write2), .pc_write_cond_o(pc_write_cond2),
        .ir_write_o(ir_write2), .mem_write_o(mem_write2), .a_b_write_o(a_b_write2),
        .alu_out_write_o(alu_out_write2), .reg_write_o(reg_write2), .reg_dst_o(reg_dst2),
        .mem_to_reg_o(mem_to_reg2), .mdr_write_o(mdr_write2), .epc_write_o(epc_write2),
        .state_dbg_o(state_dbg2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    // From FETCH, walk FETCH_WAIT, IR_LOAD and DECODE (MemWait=1 instance).
    task automatic fetch_path(input string tag);
        step();
        check_eq({tag, "_fw"}, state_dbg, SFetchWait);
        step();
        check_eq({tag, "_ir"}, state_dbg, SIrLoad);
        check_eq({tag, "_ir_wr"}, ir_write, 1);
        step();
        check_eq({tag, "_dec"}, state_dbg, SDecode);
        check_eq({tag, "_dec_srcb"}, alu_src_b, 3);
        check_eq({tag, "_dec_abw"}, a_b_write, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "simulation timeout");
    end

    initial begin
        repeat (3) step();
        check_eq("rst_state", state_dbg, SFetch);
        check_eq("rst_srcb", alu_src_b, 1);
        check_eq("rst_aluop", alu_op, 0);
        check_eq("rst_pcw", pc_write, 0);
        rst_ni = 1'b1;
        step();
        check_eq("fetch_state", state_dbg, SFetch);
        check_eq("fetch_srcb", alu_src_b, 1);
        check_eq("fetch_pcw", pc_write, 1);
        check_eq("fetch_srca", alu_src_a, 0);
        step();
        check_eq("fw_irw", ir_write, 0);
        step();
        check_eq("ir_irw", ir_write, 1);
        step();
        check_eq("add_dec_aow", alu_out_write, 1);
        step();
        check_eq("add_exec", state_dbg, SRExec);
        check_eq("add_srca", alu_src_a, 1);
        check_eq("add_srcb", alu_src_b, 0);
        check_eq("add_op", alu_op, 0);
        step();
        check_eq("add_wb", state_dbg, SRWb);
        check_eq("add_regw", reg_write, 1);
        check_eq("add_regdst", reg_dst, 1);
        check_eq("add_m2r", mem_to_reg, 0);
        step();
        check_eq("add_ret", state_dbg, SFetch);

        // ADDI with overflow: no write, then exception
        opcode_i = 6'h08;
        fetch_path("addi");
        step();
        check_eq("addi_exec", state_dbg, SAddi);
        check_eq("addi_srcb", alu_src_b, 2);
        overflow_i = 1'b1;
        step();
        overflow_i = 1'b0;
        check_eq("addi_wb", state_dbg, SImmWb);
        check_eq("addi_regw", reg_write, 0);
        step();
        check_eq("addi_exc", state_dbg, SExc);
        check_eq("addi_epcw", epc_write, 1);
        check_eq("addi_pcsrc", pc_source, 3);
        check_eq("addi_pcw", pc_write, 1);
        step();
        check_eq("addi_ret", state_dbg, SFetch);

        // ORI ignores overflow
        opcode_i = 6'h0D;
        fetch_path("ori");
        step();
        check_eq("ori_exec", state_dbg, SOri);
        check_eq("ori_srcb", alu_src_b, 4);
        check_eq("ori_op", alu_op, 3);
        overflow_i = 1'b1;
        step();
        overflow_i = 1'b0;
        check_eq("ori_wb", state_dbg, SImmWb);
        check_eq("ori_regw", reg_write, 1);
        check_eq("ori_regdst", reg_dst, 0);
        step();
        check_eq("ori_ret", state_dbg, SFetch);

        // SLL uses shamt on A; overflow does not trap
        opcode_i = 6'h00;
        funct_i = 6'h00;
        fetch_path("sll");
        step();
        check_eq("sll_srca", alu_src_a, 2);
        check_eq("sll_op", alu_op, 5);
        overflow_i = 1'b1;
        step();
        overflow_i = 1'b0;
        check_eq("sll_regw", reg_write, 1);
        step();
        check_eq("sll_ret", state_dbg, SFetch);

        // SUB with overflow traps
        funct_i = 6'h22;
        fetch_path("sub");
        step();
        check_eq("sub_op", alu_op, 1);
        overflow_i = 1'b1;
        step();
        overflow_i = 1'b0;
        check_eq("sub_wb", state_dbg, SRWb);
        check_eq("sub_regw", reg_write, 0);
        step();
        check_eq("sub_exc", state_dbg, SExc);
        step();
        check_eq("sub_ret", state_dbg, SFetch);

        // Unknown funct
        funct_i = 6'h3F;
        fetch_path("badfn");
        step();
        check_eq("badfn_exec", state_dbg, SRExec);
        step();
        check_eq("badfn_exc", state_dbg, SExc);
        step();
        check_eq("badfn_ret", state_dbg, SFetch);

        // BEQ taken and not taken both return to FETCH
        opcode_i = 6'h04;
        for (int k = 0; k < 2; k++) begin
            fetch_path("beq");
            step();
            check_eq("beq_state", state_dbg, SBeq);
            check_eq("beq_srcb", alu_src_b, 0);
            check_eq("beq_op", alu_op, 1);
            check_eq("beq_pwc", pc_write_cond, 1);
            check_eq("beq_pcsrc", pc_source, 1);
            alu_zero_i = (k == 0);
            step();
            check_eq("beq_ret", state_dbg, SFetch);
        end
        alu_zero_i = 1'b0;

        opcode_i = 6'h02;
        fetch_path("j");
        step();
        check_eq("j_state", state_dbg, SJump);
        check_eq("j_pcsrc", pc_source, 2);
        check_eq("j_pcw", pc_write, 1);
        step();
        check_eq("j_ret", state_dbg, SFetch);

        opcode_i = 6'h2B;
        fetch_path("sw");
        step();
        check_eq("sw_addr", state_dbg, SMemAddr);
        check_eq("sw_srcb", alu_src_b, 2);
        step();
        check_eq("sw_state", state_dbg, SSw);
        check_eq("sw_memw", mem_write, 1);
        step();
        check_eq("sw_ret", state_dbg, SFetch);
        check_eq("sw_memw_off", mem_write, 0);

        // Unknown opcode, then asynchronous reset in the middle of EXC
        opcode_i = 6'h3F;
        fetch_path("badop");
        step();
        check_eq("badop_exc", state_dbg, SExc);
        check_eq("badop_epcw", epc_write, 1);
        #2 rst_ni = 1'b0;
        #1;
        check_eq("arst_epcw", epc_write, 0);
        check_eq("arst_pcw", pc_write, 0);
        check_eq("arst_state", state_dbg, SFetch);

        // LW on both instances
        opcode_i = 6'h23;
        step();
        step();
        rst_ni = 1'b1;
        step();
        for (int i = 0; i < 11; i++) begin
            if (i > 0) step();
            check_eq($sformatf("lw1_state%0d", i), state_dbg, lw1_seq[i]);
            check_eq($sformatf("lw2_state%0d", i), state_dbg2, lw2_seq[i]);
            if (i == 5) check_eq("lw2_srcb", alu_src_b2, 2);
            if (i == 8) check_eq("lw2_mdrw", mdr_write2, 1);
            if (i == 9) begin
                check_eq("lw2_regw", reg_write2, 1);
                check_eq("lw2_m2r", mem_to_reg2, 1);
            end
            if (i == 7) check_eq("lw1_regw", reg_write, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
